trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_exception_code_f, input, 4 bits: fetch-stage exception code; value `NO_E means no exception.
REQ-004 SHALL have port i_exception_code_e, input, 4 bits: execute-stage exception code; value `NO_E means no exception.
REQ-005 SHALL have ports i_pc_f and i_pc_e, input, 32 bits each: PC of the instruction in the fetch and execute stages.
REQ-006 SHALL have port i_alu_out_e, input, 32 bits: execute-stage effective address, used as the faulting address for loads and stores.
REQ-007 SHALL have port i_mret_e, input, 1 bit: an mret instruction is in the execute stage.
REQ-008 SHALL have ports i_csr_mepc and i_trap_vector, input, 32 bits each: current mepc value and trap handler base address.
REQ-009 SHALL have ports o_flush_f, o_flush_d and o_flush_e, output, 1 bit each: pipeline-register flush requests.
REQ-010 SHALL have port o_stall, output, 1 bit: hold PC and the pipeline registers.
REQ-011 SHALL have ports o_csr_we (1 bit), o_csr_addr (12 bits) and o_csr_wdata (32 bits), all outputs: the CSR write port.
REQ-012 SHALL have ports o_pc_redirect (1 bit) and o_pc_target (32 bits), outputs: load PC with the target.
REQ-013 SHALL have port o_pc_state, output, 2 bits: current PC region, one of `PC_RESET_V, `PC_TXT or `PC_TRAP_V.
REQ-014 SHALL have ports o_busy and o_halted, outputs, 1 bit each: sequencer busy; double-fault lock.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, WR_MEPC, WR_MCAUSE, WR_MTVAL, REDIRECT, RET and HALT.
REQ-016 SHALL, in IDLE, prioritise as follows: E-stage exception over F-stage exception over i_mret_e.
REQ-017 SHALL, on accepting an exception in IDLE, latch the code, the PC of that stage and the tval value, then enter FLUSH on the next edge.
REQ-018 SHALL define tval as: i_alu_out_e for load/store misaligned or fault codes; i_pc_f for `E_FETCH_ADDR_MISALIGNED; 0 for all other codes.
REQ-019 SHALL, in FLUSH, assert all three flush outputs for exactly one cycle, then go to WR_MEPC.
REQ-020 SHALL, in WR_MEPC, WR_MCAUSE and WR_MTVAL, assert o_csr_we for one cycle each, with o_csr_addr 0x341, 0x342 and 0x343 respectively.
REQ-021 SHALL drive o_csr_wdata with the latched PC in WR_MEPC, {28'b0, code} in WR_MCAUSE and the latched tval in WR_MTVAL.
REQ-022 SHALL, in REDIRECT, assert o_pc_redirect with o_pc_target = i_trap_vector, set o_pc_state to `PC_TRAP_V, then return to IDLE.
REQ-023 SHALL, for an accepted mret in IDLE, enter RET; RET SHALL assert o_flush_f, o_flush_d, o_pc_redirect and o_pc_target = i_csr_mepc, set o_pc_state to `PC_TXT, then return to IDLE.
REQ-024 SHALL make exception latency 5 cycles: from the accepting edge to the end of REDIRECT; mret latency SHALL be 1 cycle.
REQ-025 SHALL assert o_stall and o_busy in every non-IDLE state, and in HALT.
REQ-026 SHALL ignore all exception and mret inputs while not in IDLE.
REQ-027 SHALL treat an exception accepted while o_pc_state = `PC_TRAP_V as a double fault: enter HALT instead of FLUSH.
REQ-028 SHALL make HALT sticky until reset, with o_halted=1 and o_stall=1, and with no CSR writes and no redirects.
REQ-029 SHALL hold o_csr_we, o_pc_redirect and all flush outputs at 0 in any cycle not named above.

Reset
REQ-030 SHALL, while i_rst_n=0, asynchronously force: state IDLE, o_pc_state `PC_RESET_V, all other outputs 0, latched registers 0.
REQ-031 SHALL abort any in-progress sequence on reset, performing no partial further CSR writes after release.
REQ-032 SHALL change o_pc_state from `PC_RESET_V only through REQ-022 or REQ-023.

Structure
REQ-033 SHALL take exception codes, PC states and CSR addresses 0x341/0x342/0x343 from the shared Constants.vh; FSM state encodings SHALL remain local.
REQ-034 SHALL be a single module with no sub-modules; the tval/cause select SHALL be a combinational block inside it.

Verification
REQ-035 Bench: i_exception_code_e=`E_LOAD_ADDR_MISALIGNED, i_pc_e=0x00080010, i_alu_out_e=0x00100002 -> flush; then CSR writes 0x341=0x00080010, 0x342=code, 0x343=0x00100002; redirect to i_trap_vector; o_pc_state=`PC_TRAP_V.
REQ-036 Bench: simultaneous F `E_FETCH_ADDR_MISALIGNED and E `E_STORE_ADDR_FAULT -> E code written to mcause; F ignored.
REQ-037 Bench: i_mret_e=1 with i_csr_mepc=0x00080024 -> next cycle o_pc_redirect=1, target 0x00080024, o_pc_state=`PC_TXT, no CSR write.
REQ-038 Bench: second exception while o_pc_state=`PC_TRAP_V -> o_halted=1 and o_stall=1 held for 100 cycles; release only by reset.
REQ-039 Bench: i_rst_n low during WR_MCAUSE -> outputs 0 immediately, o_pc_state=`PC_RESET_V, no 0x343 write after release.
REQ-040 Bench: exception pulse arriving during busy cycles -> ignored; exactly one three-write sequence observed.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer_pkg
// Description : Exception codes, PC-region codes and CSR addresses shared by
//               the trap sequencer and its surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_sequencer_pkg;

    typedef logic [3:0] exc_code_t;
    typedef logic [1:0] pc_state_t;

    // Code values follow the machine-mode mcause numbering
    localparam exc_code_t E_FETCH_ADDR_MISALIGNED = 4'd0;
    localparam exc_code_t E_FETCH_ACCESS_FAULT    = 4'd1;
    localparam exc_code_t E_ILLEGAL_INSTR         = 4'd2;
    localparam exc_code_t E_BREAKPOINT            = 4'd3;
    localparam exc_code_t E_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam exc_code_t E_LOAD_ACCESS_FAULT     = 4'd5;
    localparam exc_code_t E_STORE_ADDR_MISALIGNED = 4'd6;
    localparam exc_code_t E_STORE_ADDR_FAULT      = 4'd7;
    localparam exc_code_t E_ECALL_M               = 4'd11;
    localparam exc_code_t NO_E                    = 4'd15;

    localparam pc_state_t PC_RESET_V = 2'd0;
    localparam pc_state_t PC_TXT     = 2'd1;
    localparam pc_state_t PC_TRAP_V  = 2'd2;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

endpackage
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Serialises trap entry (flush, mepc/mcause/mtval writes,
//               redirect) and mret return; locks up on a double fault.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_exception_code_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    input  logic [31:0] i_csr_mepc,
    input  logic [31:0] i_trap_vector,
    output logic        o_flush_f,
    output logic        o_flush_d,
    output logic        o_flush_e,
    output logic        o_stall,
    output logic        o_csr_we,
    output logic [11:0] o_csr_addr,
    output logic [31:0] o_csr_wdata,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_target,
    output logic [1:0]  o_pc_state,
    output logic        o_busy,
    output logic        o_halted
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FLUSH     = 3'd1;
    localparam logic [2:0] S_WR_MEPC   = 3'd2;
    localparam logic [2:0] S_WR_MCAUSE = 3'd3;
    localparam logic [2:0] S_WR_MTVAL  = 3'd4;
    localparam logic [2:0] S_REDIRECT  = 3'd5;
    localparam logic [2:0] S_RET       = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    logic [2:0]  r_state;
    pc_state_t   r_pc_state;
    exc_code_t   r_code;
    logic [31:0] r_epc;
    logic [31:0] r_tval;

    exc_code_t   w_code;
    logic [31:0] w_epc;
    logic [31:0] w_tval;
    logic        w_exc_valid;

    // Execute-stage exception is older than the fetch-stage one and wins
    always_comb begin
        w_code = i_exception_code_f;
        w_epc  = i_pc_f;
        if (i_exception_code_e != NO_E) begin
            w_code = i_exception_code_e;
            w_epc  = i_pc_e;
        end
        w_exc_valid = (w_code != NO_E);
        case (w_code)
            E_LOAD_ADDR_MISALIGNED,
            E_LOAD_ACCESS_FAULT,
            E_STORE_ADDR_MISALIGNED,
            E_STORE_ADDR_FAULT:       w_tval = i_alu_out_e;
            E_FETCH_ADDR_MISALIGNED:  w_tval = i_pc_f;
            default:                  w_tval = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_pc_state <= PC_RESET_V;
            r_code     <= 4'h0;
            r_epc      <= 32'h0;
            r_tval     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_exc_valid) begin
                        r_code  <= w_code;
                        r_epc   <= w_epc;
                        r_tval  <= w_tval;
                        // A fault while still in the handler region cannot be recovered
                        r_state <= (r_pc_state == PC_TRAP_V) ? S_HALT : S_FLUSH;
                    end else if (i_mret_e) begin
                        r_state    <= S_RET;
                        r_pc_state <= PC_TXT;
                    end
                end
                S_FLUSH:     r_state <= S_WR_MEPC;
                S_WR_MEPC:   r_state <= S_WR_MCAUSE;
                S_WR_MCAUSE: r_state <= S_WR_MTVAL;
                S_WR_MTVAL: begin
                    r_state    <= S_REDIRECT;
                    r_pc_state <= PC_TRAP_V;
                end
                S_REDIRECT:  r_state <= S_IDLE;
                S_RET:       r_state <= S_IDLE;
                S_HALT:      r_state <= S_HALT;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_flush_f     = 1'b0;
        o_flush_d     = 1'b0;
        o_flush_e     = 1'b0;
        o_csr_we      = 1'b0;
        o_csr_addr    = 12'h0;
        o_csr_wdata   = 32'h0;
        o_pc_redirect = 1'b0;
        o_pc_target   = 32'h0;
        o_stall       = (r_state != S_IDLE);
        o_busy        = (r_state != S_IDLE);
        o_halted      = (r_state == S_HALT);
        o_pc_state    = r_pc_state;
        case (r_state)
            S_FLUSH: begin
                o_flush_f = 1'b1;
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
            end
            S_WR_MEPC: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = r_epc;
            end
            S_WR_MCAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = {28'h0, r_code};
            end
            S_WR_MTVAL: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MTVAL;
                o_csr_wdata = r_tval;
            end
            S_REDIRECT: begin
                o_pc_redirect = 1'b1;
                o_pc_target   = i_trap_vector;
            end
            S_RET: begin
                o_flush_f     = 1'b1;
                o_flush_d     = 1'b1;
                o_pc_redirect = 1'b1;
                o_pc_target   = i_csr_mepc;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Self-checking bench for trap_sequencer against a
//               transaction-level model of trap entry and mret return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  exc_f, exc_e;
    logic [31:0] pc_f, pc_e, alu_e, csr_mepc, trap_vec;
    logic        mret_e;
    logic        o_flush_f, o_flush_d, o_flush_e, o_stall, o_csr_we;
    logic [11:0] o_csr_addr;
    logic [31:0] o_csr_wdata, o_pc_target;
    logic        o_pc_redirect, o_busy, o_halted;
    logic [1:0]  o_pc_state;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_exception_code_f (exc_f),
        .i_exception_code_e (exc_e),
        .i_pc_f             (pc_f),
        .i_pc_e             (pc_e),
        .i_alu_out_e        (alu_e),
        .i_mret_e           (mret_e),
        .i_csr_mepc         (csr_mepc),
        .i_trap_vector      (trap_vec),
        .o_flush_f          (o_flush_f),
        .o_flush_d          (o_flush_d),
        .o_flush_e          (o_flush_e),
        .o_stall            (o_stall),
        .o_csr_we           (o_csr_we),
        .o_csr_addr         (o_csr_addr),
        .o_csr_wdata        (o_csr_wdata),
        .o_pc_redirect      (o_pc_redirect),
        .o_pc_target        (o_pc_target),
        .o_pc_state         (o_pc_state),
        .o_busy             (o_busy),
        .o_halted           (o_halted)
    );

    typedef struct packed {
        logic        ff, fd, fe, stall, busy, halted, we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] target;
        logic [1:0]  pcs;
    } obs_t;

    obs_t obs;
    assign obs = {o_flush_f, o_flush_d, o_flush_e, o_stall, o_busy, o_halted, o_csr_we,
                  o_csr_addr, o_csr_wdata, o_pc_redirect, o_pc_target, o_pc_state};

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    logic [1:0] m_pcs;
    bit   m_halted;
    bit   cur_idle;

    function automatic obs_t idle_rec();
        obs_t r = '0;
        r.pcs = m_pcs;
        if (m_halted) begin
            r.stall = 1'b1; r.busy = 1'b1; r.halted = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input obs_t e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Expand an accepted request into the cycle-by-cycle outputs it must produce
    task automatic model_edge();
        logic [3:0]  code;
        logic [31:0] epc, tval;
        obs_t        b, r;
        if (!(cur_idle && !m_halted && exp_q.size() == 0)) return;
        if (exc_e != NO_E || exc_f != NO_E) begin
            if (exc_e != NO_E) begin code = exc_e; epc = pc_e; end
            else               begin code = exc_f; epc = pc_f; end
            if (code == E_LOAD_ADDR_MISALIGNED || code == E_LOAD_ACCESS_FAULT ||
                code == E_STORE_ADDR_MISALIGNED || code == E_STORE_ADDR_FAULT)
                tval = alu_e;
            else if (code == E_FETCH_ADDR_MISALIGNED)
                tval = pc_f;
            else
                tval = 32'h0;
            if (m_pcs == PC_TRAP_V) begin
                m_halted = 1'b1;
            end else begin
                b = '0; b.stall = 1'b1; b.busy = 1'b1; b.pcs = m_pcs;
                r = b; r.ff = 1'b1; r.fd = 1'b1; r.fe = 1'b1; exp_q.push_back(r);
                r = b; r.we = 1'b1; r.addr = 12'h341; r.wdata = epc; exp_q.push_back(r);
                r = b; r.we = 1'b1; r.addr = 12'h342; r.wdata = 32'(code); exp_q.push_back(r);
                r = b; r.we = 1'b1; r.addr = 12'h343; r.wdata = tval; exp_q.push_back(r);
                r = b; r.redir = 1'b1; r.target = trap_vec; r.pcs = PC_TRAP_V; exp_q.push_back(r);
                m_pcs = PC_TRAP_V;
            end
        end else if (mret_e) begin
            r = '0; r.stall = 1'b1; r.busy = 1'b1; r.ff = 1'b1; r.fd = 1'b1;
            r.redir = 1'b1; r.target = csr_mepc; r.pcs = PC_TXT;
            exp_q.push_back(r);
            m_pcs = PC_TXT;
        end
    endtask

    task automatic tick(input string tag);
        obs_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = idle_rec();
            cur_idle = 1'b1;
        end
        check(tag, e);
    endtask

    task automatic quiet();
        exc_e = NO_E; exc_f = NO_E; mret_e = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        quiet();
        #1;
        exp_q.delete();
        m_pcs = PC_RESET_V; m_halted = 1'b0; cur_idle = 1'b1;
        check({tag, "_async"}, idle_rec());
        @(posedge clk);
        #1;
        check({tag, "_hold"}, idle_rec());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        pc_f = 32'h0; pc_e = 32'h0; alu_e = 32'h0;
        csr_mepc = 32'h0; trap_vec = 32'h0000_0100;
        m_pcs = PC_RESET_V; m_halted = 1'b0; cur_idle = 1'b1;
        #3;
        check("reset_state", idle_rec());
        @(posedge clk);
        #1;
        check("reset_hold", idle_rec());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick("idle");

        // Load misaligned in execute stage
        exc_e = E_LOAD_ADDR_MISALIGNED; pc_e = 32'h0008_0010; alu_e = 32'h0010_0002;
        trap_vec = 32'h0000_0100;
        tick("ld_mis_flush");
        quiet();
        repeat (6) tick("ld_mis_seq");

        // mret back to text region
        mret_e = 1'b1; csr_mepc = 32'h0008_0024;
        tick("mret_redirect");
        quiet();
        repeat (2) tick("mret_after");

        // Simultaneous fetch and execute exceptions
        exc_f = E_FETCH_ADDR_MISALIGNED; pc_f = 32'h0008_0031;
        exc_e = E_STORE_ADDR_FAULT; pc_e = 32'h0008_002C; alu_e = 32'h2000_0040;
        trap_vec = 32'h0000_0200;
        tick("prio_flush");
        quiet();
        repeat (6) tick("prio_seq");
        mret_e = 1'b1; csr_mepc = 32'h0008_0030;
        tick("prio_mret");
        quiet();

        // Requests pulsed while the sequencer is busy must be dropped
        exc_e = E_ILLEGAL_INSTR; pc_e = 32'h0008_0040;
        tick("busy_flush");
        for (int i = 0; i < 4; i++) begin
            exc_e = 4'($urandom_range(0, 14)); exc_f = E_FETCH_ADDR_MISALIGNED;
            pc_e = $urandom; pc_f = $urandom; alu_e = $urandom; mret_e = 1'b1;
            tick("busy_ignore");
        end
        quiet();
        repeat (4) tick("busy_tail");
        mret_e = 1'b1; csr_mepc = 32'h0008_0044;
        tick("busy_mret");
        quiet();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(0, 5) == 0) begin
                do_reset("rand_reset");
            end else begin
                if (cur_idle && exp_q.size() == 0) begin
                    trap_vec = $urandom; csr_mepc = $urandom;
                end
                exc_e  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : NO_E;
                exc_f  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : NO_E;
                mret_e = ($urandom_range(0, 3) == 0);
                pc_e = $urandom; pc_f = $urandom; alu_e = $urandom;
                tick("rand");
            end
        end
        quiet();

        // Reset while writing mcause aborts the remaining writes
        do_reset("pre_abort");
        exc_e = E_STORE_ADDR_MISALIGNED; pc_e = 32'h0008_0050; alu_e = 32'h0010_0007;
        tick("abort_flush");
        quiet();
        tick("abort_mepc");
        tick("abort_mcause");
        do_reset("abort_rst");
        repeat (8) tick("abort_after");

        // Double fault locks the sequencer until reset
        exc_e = E_BREAKPOINT; pc_e = 32'h0008_0060; trap_vec = 32'h0000_0300;
        tick("df_first");
        quiet();
        repeat (5) tick("df_first_seq");
        exc_e = E_ECALL_M; pc_e = 32'h0000_0304;
        tick("df_halt");
        for (int i = 0; i < 100; i++) begin
            exc_e = 4'($urandom_range(0, 15)); exc_f = 4'($urandom_range(0, 15));
            mret_e = 1'($urandom_range(0, 1));
            tick("df_hold");
        end
        do_reset("df_rst");
        repeat (3) tick("df_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
